// File: rtl/gsu_cache_ctrl.sv
// gsu_cache_ctrl -- sequencer for the 512-byte GSU instruction cache
//
// Purpose:
//   Resolves GSU opcode fetches against a 32 x 16-byte cache that is windowed
//   by CBR. A hit reads the gsu_cache RAM. A miss fills the whole line from
//   Game Pak ROM, answers the fetch, and then marks the line valid. A fetch
//   outside the window is served straight from ROM and leaves the cache alone.
//   Also handles CBR loads, flag flushes and SNES-side cache writes made while
//   the GSU is stopped.
//
// Ports:
//   clkin, RESET              clock, asynchronous active-high reset
//   go                        SFR G flag; fetches are accepted only while high
//   fetch_req/addr/ack/data   GSU opcode fetch handshake (ack is a 1-cycle pulse)
//   cbr_load, cbr_in          load CBR (low nibble forced to 0) and clear flags
//   flush                     clear all line flags, CBR unchanged
//   snes_we/addr/wdata        SNES write into the cache while the GSU is stopped
//   rom_req/addr/ack/data     ROM read port toward the bus arbiter
//   cache_addr/din/we/dout    gsu_cache port A (read data has 1-cycle latency)
//   cbr, cache_flags          current CBR and per-line valid flags
//
// Build option:
//   GSU_CACHE_STATS_EN  adds saturating hit_cnt / miss_cnt outputs.

module gsu_cache_ctrl #(
    parameter int NUM_LINES  = 32,
    parameter int LINE_BYTES = 16,
    parameter int CACHE_AW   = 9
) (
    input  logic                 clkin,
    input  logic                 RESET,
    input  logic                 go,
    input  logic                 fetch_req,
    input  logic [23:0]          fetch_addr,
    output logic                 fetch_ack,
    output logic [7:0]           fetch_data,
    input  logic                 cbr_load,
    input  logic [15:0]          cbr_in,
    input  logic                 flush,
    input  logic                 snes_we,
    input  logic [CACHE_AW-1:0]  snes_addr,
    input  logic [7:0]           snes_wdata,
    output logic                 rom_req,
    output logic [23:0]          rom_addr,
    input  logic                 rom_ack,
    input  logic [7:0]           rom_data,
    output logic [CACHE_AW-1:0]  cache_addr,
    output logic [7:0]           cache_din,
    output logic                 cache_we,
    input  logic [7:0]           cache_dout,
    output logic [15:0]          cbr,
`ifdef GSU_CACHE_STATS_EN
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt,
`endif
    output logic [NUM_LINES-1:0] cache_flags
);

    localparam int LW = $clog2(NUM_LINES);
    localparam int BW = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        HIT_RD,
        FILL_REQ,
        FILL_WR,
        FILL_DONE,
        UNC_REQ
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cbr_q;
    logic [NUM_LINES-1:0] flags_q;
    logic [LW-1:0]        line_q;      // cache line being filled
    logic [15-BW:0]       base_q;      // line base address above the byte offset
    logic [7:0]           bank_q;      // PBR of the fetch being filled
    logic [BW-1:0]        beat_q;      // byte of the line currently transferred
    logic [BW-1:0]        byte_sel_q;  // byte the GSU actually asked for
    logic [7:0]           rom_byte_q;  // ROM byte waiting to be written
    logic [7:0]           result_q;    // fetch answer collected during a fill
    logic [7:0]           hit_data_q;  // fetch answer read from the cache
    logic                 ack_q;       // hit answer pending this cycle
    logic                 stale_q;     // flags were cleared while this fill ran

    logic [15:0]          off;
    logic                 in_window;
    logic [LW-1:0]        off_line;
    logic                 clear;
    logic                 snes_ok;
    logic                 fill_start;
    logic                 unused_cbr_low;

    // Window test: offset from CBR with 16-bit wrap-around.
    assign off        = fetch_addr[15:0] - cbr_q;
    assign in_window  = (off[15:CACHE_AW] == '0);
    assign off_line   = off[CACHE_AW-1:BW];
    assign clear      = cbr_load | flush;
    assign snes_ok    = snes_we && !go && (state_q == IDLE);
    assign fill_start = (state_q == IDLE) && (state_d == FILL_REQ);

    // The low nibble of CBR is hard-wired to zero.
    assign unused_cbr_low = ^cbr_in[3:0];

    assign cbr         = cbr_q;
    assign cache_flags = flags_q;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values from before the edge, independent of block order.
    always_ff @(posedge clkin or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case statement;
    // a path that left one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_ack  = 1'b0;
        fetch_data = '0;
        rom_req    = 1'b0;
        rom_addr   = '0;
        cache_addr = '0;
        cache_din  = '0;
        cache_we   = 1'b0;

        case (state_q)
            IDLE: begin
                // A hit answer is presented here, one cycle after HIT_RD, while
                // the requester is still holding fetch_req; do not re-accept it.
                if (ack_q) begin
                    fetch_ack  = 1'b1;
                    fetch_data = hit_data_q;
                end
                if (go) begin
                    if (fetch_req && !ack_q) begin
                        if (!in_window) begin
                            state_d = UNC_REQ;
                        end else if (flags_q[off_line]) begin
                            cache_addr = off[CACHE_AW-1:0];
                            state_d    = HIT_RD;
                        end else begin
                            state_d = FILL_REQ;
                        end
                    end
                end else if (snes_we) begin
                    cache_we   = 1'b1;
                    cache_addr = snes_addr;
                    cache_din  = snes_wdata;
                end
            end

            // RAM output for the address driven in IDLE becomes valid here.
            HIT_RD: state_d = IDLE;

            FILL_REQ: begin
                rom_req  = 1'b1;
                rom_addr = {bank_q, base_q, beat_q};
                if (rom_ack) state_d = FILL_WR;
            end

            FILL_WR: begin
                cache_we   = 1'b1;
                cache_addr = {line_q, beat_q};
                cache_din  = rom_byte_q;
                state_d    = (beat_q == BW'(LINE_BYTES - 1)) ? FILL_DONE : FILL_REQ;
            end

            FILL_DONE: begin
                fetch_ack  = 1'b1;
                fetch_data = result_q;
                state_d    = IDLE;
            end

            UNC_REQ: begin
                rom_req  = 1'b1;
                rom_addr = fetch_addr;
                if (rom_ack) begin
                    fetch_ack  = 1'b1;
                    fetch_data = rom_data;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge RESET) begin
        if (RESET) begin
            cbr_q      <= '0;
            flags_q    <= '0;
            line_q     <= '0;
            base_q     <= '0;
            bank_q     <= '0;
            beat_q     <= '0;
            byte_sel_q <= '0;
            rom_byte_q <= '0;
            result_q   <= '0;
            hit_data_q <= '0;
            ack_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            ack_q <= (state_q == HIT_RD);
            if (state_q == HIT_RD) hit_data_q <= cache_dout;

            if (fill_start) begin
                line_q     <= off_line;
                base_q     <= fetch_addr[15:BW];
                bank_q     <= fetch_addr[23:16];
                byte_sel_q <= off[BW-1:0];
                beat_q     <= '0;
            end

            if (state_q == FILL_REQ && rom_ack) rom_byte_q <= rom_data;

            if (state_q == FILL_WR) begin
                if (beat_q == byte_sel_q) result_q <= rom_byte_q;
                beat_q <= beat_q + 1'b1;
            end

            // A clear at acceptance or at any point of the fill means the line
            // was filled against flags (and possibly a CBR) that no longer hold.
            if (fill_start)  stale_q <= clear;
            else if (clear)  stale_q <= 1'b1;

            if (cbr_load) cbr_q <= {cbr_in[15:4], 4'h0};

            // Clear has priority over both ways of setting a flag.
            if (clear) begin
                flags_q <= '0;
            end else begin
                if (state_q == FILL_DONE && !stale_q) flags_q[line_q] <= 1'b1;
                if (snes_ok && (snes_addr[BW-1:0] == BW'(LINE_BYTES - 1)))
                    flags_q[snes_addr[CACHE_AW-1:BW]] <= 1'b1;
            end
        end
    end

`ifdef GSU_CACHE_STATS_EN
    always_ff @(posedge clkin or posedge RESET) begin
        if (RESET) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (cbr_load) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state_q == HIT_RD && hit_cnt != 16'hFFFF) hit_cnt  <= hit_cnt + 16'd1;
            if (fill_start && miss_cnt != 16'hFFFF)       miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/gsu_cache_ctrl.md
Name: gsu_cache_ctrl

Overview:
- Sequences the 512-byte GSU instruction cache: 32 lines × 16 bytes, windowed by CBR.
- Resolves GSU opcode fetches as cache hits or misses.
- On a miss, fills the whole line from Game Pak ROM and then sets the line's valid flag.
- Also handles CBR loads, flag flushes, and SNES-side cache writes while the GSU is stopped.
- Sits between the GSU fetch stage, the gsu_cache dual-port RAM and the ROM bus arbiter.

Parameters:
- NUM_LINES, 32, number of cache lines; width of the flag vector.
- LINE_BYTES, 16, bytes per line; fill burst length.
- CACHE_AW, 9, cache RAM address width (log2(NUM_LINES*LINE_BYTES)).

Ports:
- clkin  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- go  in  1  SFR G flag; fetches are legal only while high
- fetch_req  in  1  GSU opcode fetch request, held until fetch_ack
- fetch_addr  in  24  {PBR, R15} of the opcode
- fetch_ack  out  1  one-cycle pulse; fetch_data is valid in the same cycle
- fetch_data  out  8  opcode byte
- cbr_load  in  1  one-cycle pulse (CACHE/LJMP): load CBR and clear all flags
- cbr_in  in  16  new CBR; bits [3:0] are ignored and forced to 0
- flush  in  1  one-cycle pulse: clear all flags, CBR unchanged
- snes_we  in  1  SNES write to $3100-$32FF
- snes_addr  in  9  cache byte offset
- snes_wdata  in  8  write data
- rom_req  out  1  ROM read request, held until rom_ack
- rom_addr  out  24  ROM byte address
- rom_ack  in  1  rom_data valid this cycle
- rom_data  in  8  ROM byte
- cache_addr  out  9  cache RAM port A address
- cache_din  out  8  port A write data
- cache_we  out  1  port A write enable
- cache_dout  in  8  port A read data, 1-cycle latency
- cbr  out  16  current CBR
- cache_flags  out  32  line valid flags

Behaviour:
- Reset values: cbr=0, cache_flags=0, state=IDLE. fetch_ack, rom_req, cache_we=0. fetch_data, rom_addr, cache_addr, cache_din=0.
- Window test, combinational: off = fetch_addr[15:0] - cbr (16-bit, wraps). The fetch is in window iff off[15:9]==0; line = off[8:4], byte = off[3:0].
- State machine states: IDLE, HIT_RD, FILL_REQ, FILL_WR, FILL_DONE, UNC_REQ.
- IDLE:
  - A fetch_req with go=1 is accepted.
  - In window and flag[line] set → drive cache_addr=off[8:0], go to HIT_RD.
  - In window and flag clear → latch the line base, beat=0, go to FILL_REQ.
  - Out of window → UNC_REQ.
- HIT_RD: next cycle fetch_ack=1 and fetch_data=cache_dout → IDLE. Hit latency is 2 cycles from acceptance to ack.
- FILL_REQ:
  - rom_req=1, rom_addr={fetch_addr[23:16], line_base + beat}, where line_base = fetch_addr[15:0] with its low 4 bits cleared.
  - On rom_ack, capture rom_data and go to FILL_WR.
  - rom_req deasserts in the cycle after rom_ack.
- FILL_WR:
  - cache_we=1, cache_addr={line, beat}, cache_din = captured byte.
  - If beat == the requested byte, also latch the byte as the fetch result.
  - If beat==15 → FILL_DONE; otherwise beat+1 → FILL_REQ.
- FILL_DONE: set flag[line] unless it is stale (see below); fetch_ack=1 with the latched byte → IDLE.
- UNC_REQ: rom_req with rom_addr=fetch_addr; on rom_ack, fetch_ack=1 and fetch_data=rom_data in the same cycle → IDLE. The cache is untouched.
- cbr_load and flush:
  - Take effect in any state: flags cleared next cycle, and cbr updated on cbr_load.
  - If either arrives during a fill, the fill runs to completion and the fetch is still answered.
  - The in-flight line is marked stale, so FILL_DONE does not set its flag.
  - cbr_load in the same cycle as FILL_DONE: the clear wins.
- SNES writes:
  - Honoured only when go=0 and state==IDLE: cache_we=1, cache_addr=snes_addr, cache_din=snes_wdata.
  - Writing byte 15 of a line (snes_addr[3:0]==15) sets flag[snes_addr[8:4]].
  - Otherwise the write is dropped. The flags are unaffected by dropped writes.
- go falling mid-operation: the current transaction completes normally.
- fetch_req with go=0: ignored, no ack.
- RESET asserted mid-fill: everything returns to reset values immediately. rom_req drops asynchronously.

Optional Feature:
- Macro: GSU_CACHE_STATS_EN.
- When defined, adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt counts HIT_RD acks; miss_cnt counts fill entries.
  - Both saturate at 16'hFFFF, and both are cleared by RESET and by cbr_load.
  - Uncached fetches are not counted.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then cbr_load with cbr_in=16'h8003: cbr=16'h8000, flags=0. Fetch 00:8025 → miss on line 2.
  - Expect 16 rom_req beats at 00:8020..00:802F.
  - Expect fetch_ack with the ROM byte at 8025, then flag[2]=1.
- Immediately fetch 00:8027 → hit: ack exactly 2 cycles after acceptance, no rom_req, data = ROM[00:8027].
- Fetch 00:7FFF and 00:8200 with cbr=8000 → both uncached: single-beat ROM reads, flags unchanged.
- Pulse flush at beat 7 of a fill on line 5 → fetch is still acked with the correct byte; flag[5] stays 0; refetch misses again.
- With go=0, SNES writes snes_addr 0x030..0x03F → flag[3]=1 only after the 0x03F write. The same writes with go=1 change nothing.
- Assert RESET during FILL_REQ → rom_req=0 and fetch_ack=0 in the same cycle; flags=0; cbr=0.
